serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, sets the clock cycles per serial bit; legal range is 1..255.
REQ-002 Parameter DATA_W, default 8, sets the payload width in bits.
REQ-003 clk  input  1  the single clock; all state changes SHALL occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 data_in  input  DATA_W  parallel word to transmit, sampled only on the accept cycle.
REQ-006 valid  input  1  data_in is offered for transmission.
REQ-007 ready  output  1  the block can accept a word this cycle.
REQ-008 tx  output  1  serial line; it is high when idle.
REQ-009 busy  output  1  a frame is in progress (any state other than IDLE).
REQ-010 done  output  1  single-cycle pulse in the last cycle of the stop bit.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP; the transitions are as follows.
- IDLE to START on accept.
- START to DATA after CLKS_PER_BIT cycles.
- DATA to STOP after DATA_W bits.
- STOP to IDLE after CLKS_PER_BIT cycles.
REQ-012 Accept SHALL occur in a cycle where valid=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-013 On accept, data_in SHALL be latched into an internal shift register; later changes to data_in SHALL NOT affect the frame.
REQ-014 Frame timing relative to an accept at edge t SHALL be as follows.
- tx=0 (start bit) for cycles t+1..t+C, where C=CLKS_PER_BIT.
- Data bit i (LSB first) for cycles t+1+C(1+i)..t+C(2+i).
- tx=1 (stop bit) for C cycles.
- done=1 in the final stop cycle.
- IDLE in the next cycle.
REQ-015 Total frame length SHALL be (DATA_W+2)*C cycles.
REQ-016 A baud counter SHALL count 0..C-1 and wrap to 0, producing a bit-end tick when it equals C-1.
REQ-017 A bit counter SHALL count 0..DATA_W-1 in DATA; the DATA-to-STOP transition SHALL occur on the tick where the bit counter equals DATA_W-1.
REQ-018 With C=1, every bit SHALL last exactly one cycle with no extra idle cycles inside the frame.
REQ-019 Back-to-back transfers: with valid held high, the next accept SHALL occur in the first IDLE cycle after done, giving exactly one idle cycle (tx=1) between frames.
REQ-020 valid asserted while busy=1 SHALL be ignored; no data is queued or lost from the current frame.
REQ-021 Outputs SHALL be registered; tx SHALL NOT glitch within a bit period.
REQ-022 busy SHALL equal (state != IDLE); done SHALL NOT be asserted in any state except STOP.

Reset
REQ-023 When rst=1 at a rising edge, the next cycle SHALL have these values.
- state=IDLE.
- tx=1, busy=0, done=0, ready=1.
- Baud counter, bit counter and shift register all 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately with no completion of the stop bit and no done pulse.
REQ-025 rst SHALL take priority over accept in the same cycle.
REQ-026 During rst=1, ready SHALL be 0.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, START, DATA, STOP) and the defaults for CLKS_PER_BIT and DATA_W.
REQ-028 The baud counter SHALL be a sub-module named baud_tick, with ports clk, rst, en and tick, and parameter CLKS_PER_BIT.
REQ-029 The shift register and FSM SHALL reside in serial_tx.

Verification
REQ-030 Reset idle: assert rst for 2 cycles, then release -> tx=1, ready=1, busy=0 and done=0, held for 20 cycles with valid=0.
REQ-031 Single frame: with C=4, send data_in=8'hA5 on accept at t -> tx sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1; done=1 at t+40; ready=1 at t+41.
REQ-032 Back-to-back: send 8'h00 then 8'hFF with valid held high -> the two frames are separated by exactly one tx=1 idle cycle; the second frame's data bits are all 1.
REQ-033 Busy ignore: change data_in to 8'h3C with valid=1 during the frame for 8'h81 -> the transmitted bits still encode 8'h81; no second frame starts until ready=1.
REQ-034 Reset mid-frame: assert rst at t+15 during DATA -> from t+16, tx=1, busy=0 and done never pulses; a subsequent 8'h55 frame is bit-exact.
REQ-035 Edge parameter: with C=1, send 8'h01 -> tx sequence is 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; done on the 10th cycle.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared FSM state encoding and parameter defaults for the serial transmitter.
package serial_tx_pkg;

    localparam int CLKS_PER_BIT_DEF = 4;
    localparam int DATA_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic int frame_cycles(input int clks_per_bit, input int data_w);
        return (data_w + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// baud_tick: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module baud_tick
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLKS_PER_BIT - 1));

    // Held at zero while idle so every frame starts on a fresh bit boundary.
    always_ff @(posedge clk)
        if (rst || !en)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/serial_tx.sv
// serial_tx: start/data/stop serial transmitter, LSB first, CLKS_PER_BIT clocks per bit.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] nshreg;
    logic [BW-1:0]     bitc;
    logic              tick;
    logic              last_bit;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

    assign busy     = state != IDLE;
    assign ready    = (state == IDLE) && !rst;
    assign done     = (state == STOP) && tick;
    assign last_bit = bitc == BW'(DATA_W - 1);
    assign nshreg   = shreg >> 1;

    // tx is loaded one cycle ahead of each bit so the line only changes on bit boundaries.
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            shreg <= '0;
            bitc  <= '0;
        end else begin
            case (state)
                IDLE:
                    if (valid) begin
                        state <= START;
                        shreg <= data_in;
                        bitc  <= '0;
                        tx    <= 1'b0;
                    end
                START:
                    if (tick) begin
                        state <= DATA;
                        tx    <= shreg[0];
                    end
                DATA:
                    if (tick) begin
                        if (last_bit) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bitc  <= bitc + 1'b1;
                            shreg <= nshreg;
                            tx    <= nshreg[0];
                        end
                    end
                STOP:
                    if (tick)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench driving a C=4 and a C=1 transmitter with shared stimulus.
module tb_serial_tx;

    localparam int C0 = 4;
    localparam int C1 = 1;
    localparam int W  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       r0, t0, b0, d0;
    logic       r1, t1, b1, d1;

    int total = 0;
    int passed = 0;
    int fails = 0;

    bit         in_frame [2];
    int         pos      [2];
    int         frames   [2];
    logic [7:0] rxw      [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    serial_tx #(.CLKS_PER_BIT(C0), .DATA_W(W)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(r0), .tx(t0), .busy(b0), .done(d0)
    );

    serial_tx #(.CLKS_PER_BIT(C1), .DATA_W(W)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(r1), .tx(t1), .busy(b1), .done(d1)
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Expected line level at cycle p of a frame carrying word w.
    function automatic logic level(input logic [7:0] w, input int c, input int p);
        if (p < c) return 1'b0;
        if (p < (W + 1) * c) return w[p / c - 1];
        return 1'b1;
    endfunction

    task automatic model_step(input int d, input int c, input logic tx_a, input logic busy_a,
                              input logic done_a, input logic ready_a);
        int         len;
        logic [7:0] w;
        logic [7:0] popped;
        int         qs;
        len = (W + 2) * c;
        qs  = (d == 0) ? q0.size() : q1.size();
        w   = (qs == 0) ? 8'h00 : ((d == 0) ? q0[0] : q1[0]);
        chk("busy", d, busy_a, in_frame[d]);
        chk("ready", d, ready_a, !in_frame[d] && !rst);
        chk("done", d, done_a, in_frame[d] && pos[d] == len - 1);
        chk("tx", d, tx_a, in_frame[d] ? level(w, c, pos[d]) : 1'b1);
        if (in_frame[d] && pos[d] >= c && pos[d] < (W + 1) * c && (pos[d] % c) == c / 2)
            rxw[d][pos[d] / c - 1] = tx_a;
        if (done_a === 1'b1) begin
            chk("done_has_frame", d, qs, 1);
            if (qs != 0) begin
                popped = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("frame_word", d, rxw[d], popped);
                frames[d]++;
            end
        end
        if (rst) begin
            in_frame[d] = 1'b0;
            pos[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
        end else if (in_frame[d]) begin
            if (pos[d] == len - 1) in_frame[d] = 1'b0;
            else pos[d]++;
        end else if (valid) begin
            if (d == 0) q0.push_back(data_in); else q1.push_back(data_in);
            in_frame[d] = 1'b1;
            pos[d] = 0;
            rxw[d] = 8'h00;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, C0, t0, b0, d0, r0);
        model_step(1, C1, t1, b1, d1, r1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (r0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_wait", 0, ok, 1);
    endtask

    task automatic send(input logic [7:0] w);
        @(posedge clk);
        #1;
        valid = 1'b1;
        data_in = w;
        wait_ready();
        cycles(1);
        valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cycles(2);
        rst = 1'b0;
        cycles(20);
        send(8'hA5);
        cycles(45);
        valid = 1'b1;
        data_in = 8'h00;
        wait_ready();
        cycles(1);
        data_in = 8'hFF;
        wait_ready();
        cycles(1);
        valid = 1'b0;
        cycles(45);
        send(8'h81);
        cycles(3);
        valid = 1'b1;
        data_in = 8'h3C;
        cycles(25);
        valid = 1'b0;
        cycles(20);
        send(8'h96);
        cycles(14);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(5);
        send(8'h55);
        cycles(45);
        send(8'h01);
        cycles(45);
        for (int i = 0; i < 2000; i++) begin
            valid   = ($urandom_range(0, 2) == 0);
            data_in = 8'($urandom);
            rst     = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        rst = 1'b0;
        valid = 1'b0;
        cycles(60);
        chk("q_empty", 0, q0.size(), 0);
        chk("q_empty", 1, q1.size(), 0);
        chk("frames_seen", 0, frames[0] >= 20, 1);
        chk("frames_seen", 1, frames[1] >= 20, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
